// File: rtl/ntt_addr_pkg.sv
// Shared types and stage-geometry helpers for the radix-4 NTT address sequencer.
// Holds the FSM state encoding and per-stage loop limits derived from log2(N).
// Exports: state_t, num_stages(), p_max(), k_last(), j_last().
package ntt_addr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int num_stages(input int aw);
        return aw / 2;
    endfunction

    function automatic int p_max(input int aw);
        return (aw / 2) - 1;
    endfunction

    // Highest group index in stage p: N/4^(p+1) - 1.
    function automatic int unsigned k_last(input int aw, input int p);
        return (32'd1 << (aw - 2 - 2 * p)) - 32'd1;
    endfunction

    // Highest offset index in stage p: 4^p - 1.
    function automatic int unsigned j_last(input int p);
        return (32'd1 << (2 * p)) - 32'd1;
    endfunction

endpackage

// File: rtl/ntt_addr_seq_if.sv
// Tuple stream from the address sequencer to the bank mapper / memory read port.
// Carries four butterfly addresses, twiddle exponent, stage index and last flag.
// Ports: master drives data + addr_valid, slave drives addr_ready.
interface ntt_addr_seq_if #(
    parameter int ADDR_W = 10,
    parameter int P_W    = 3
) ();
    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [ADDR_W-1:0] addr3;
    logic [ADDR_W-1:0] tw_exp;
    logic [P_W-1:0]    stage;
    logic              last;

    modport master (
        output addr_valid, addr0, addr1, addr2, addr3, tw_exp, stage, last,
        input  addr_ready
    );

    modport slave (
        input  addr_valid, addr0, addr1, addr2, addr3, tw_exp, stage, last,
        output addr_ready
    );
endinterface

// File: rtl/ntt_addr_map.sv
// Combinational radix-4 butterfly address map: (k, j, p) -> addr0..3, tw_exp.
// Zero latency; the caller registers the results.
// Ports: i_k group, i_j offset, i_p stage in; o_addr0..3, o_tw_exp out.
module ntt_addr_map #(
    parameter int ADDR_W = 10,
    parameter int P_W    = 3
) (
    input  logic [ADDR_W-1:0] i_k,
    input  logic [ADDR_W-1:0] i_j,
    input  logic [P_W-1:0]    i_p,
    output logic [ADDR_W-1:0] o_addr0,
    output logic [ADDR_W-1:0] o_addr1,
    output logic [ADDR_W-1:0] o_addr2,
    output logic [ADDR_W-1:0] o_addr3,
    output logic [ADDR_W-1:0] o_tw_exp
);
    logic [7:0]        w_s;      // s = 2p, widened so s+2 cannot wrap
    logic [7:0]        w_tw_sh;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_bit_lo;
    logic [ADDR_W-1:0] w_bit_hi;

    assign w_s      = 8'({i_p, 1'b0});
    assign w_base   = (i_k << (w_s + 8'd2)) | i_j;
    assign w_bit_lo = ADDR_W'(1) << w_s;
    assign w_bit_hi = w_bit_lo << 1;
    assign w_tw_sh  = 8'(ADDR_W - 2) - w_s;

    assign o_addr0  = w_base;
    assign o_addr1  = w_base | w_bit_lo;
    assign o_addr2  = w_base | w_bit_hi;
    assign o_addr3  = w_base | w_bit_lo | w_bit_hi;
    assign o_tw_exp = i_j << w_tw_sh;
endmodule

// File: rtl/ntt_addr_seq.sv
// Self-sequencing radix-4 NTT address generator walking every (p, j, k) tuple of an N=2^ADDR_W transform.
// Latency: first tuple valid one cycle after an accepted start; next tuple the cycle after each transfer.
// Backpressure: tuple held stable while addr_ready is low; abort cancels immediately without done.
// Ports: clk/rst, start/inv/abort control in, addr_if tuple stream (master), busy/done status out.
module ntt_addr_seq
    import ntt_addr_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int STAGE_GAP = 0,
    parameter int P_W       = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic inv,
    input  logic abort,
    ntt_addr_seq_if.master addr_if,
    output logic busy,
    output logic done
);
    localparam logic [P_W-1:0] P_TOP    = P_W'(p_max(ADDR_W));
    localparam logic [3:0]     GAP_INIT = (STAGE_GAP > 0) ? 4'(STAGE_GAP - 1) : 4'd0;

    state_t            r_state;
    logic [ADDR_W-1:0] r_k, r_j;
    logic [P_W-1:0]    r_p;
    logic              r_inv;
    logic [3:0]        r_gap;
    logic              r_valid, r_busy, r_done, r_last;
    logic [ADDR_W-1:0] r_addr0, r_addr1, r_addr2, r_addr3, r_tw;

    logic              w_inv_eff;
    logic [P_W-1:0]    w_p_last;
    logic [ADDR_W-1:0] w_k_lim, w_j_lim;
    logic              w_stage_end, w_final, w_xfer, w_start_ok, w_load, w_clr_last;
    logic [ADDR_W-1:0] w_k_nxt, w_j_nxt;
    logic [P_W-1:0]    w_p_nxt;
    logic              w_last_nxt;
    logic [ADDR_W-1:0] w_a0, w_a1, w_a2, w_a3, w_tw;

    // Direction is taken live from inv only while deciding the first tuple.
    assign w_inv_eff   = (r_state == ST_IDLE) ? inv : r_inv;
    assign w_p_last    = w_inv_eff ? P_TOP : '0;
    assign w_k_lim     = ADDR_W'(k_last(ADDR_W, int'(r_p)));
    assign w_j_lim     = ADDR_W'(j_last(int'(r_p)));
    assign w_stage_end = (r_k == w_k_lim) && (r_j == w_j_lim);
    assign w_final     = w_stage_end && (r_p == w_p_last);
    assign w_xfer      = r_valid && addr_if.addr_ready;
    assign w_start_ok  = (r_state == ST_IDLE) && start && !abort;
    assign w_load      = w_start_ok || (w_xfer && !abort && !w_final);
    assign w_clr_last  = (((r_state == ST_RUN) || (r_state == ST_GAP)) && abort) ||
                         (w_xfer && w_final);

    // Next tuple: k fastest, then j, then step p in the transform direction.
    always_comb begin
        w_k_nxt = r_k;
        w_j_nxt = r_j;
        w_p_nxt = r_p;
        if (r_state == ST_IDLE) begin
            w_k_nxt = '0;
            w_j_nxt = '0;
            w_p_nxt = inv ? '0 : P_TOP;
        end else if (r_k != w_k_lim) begin
            w_k_nxt = r_k + 1'b1;
        end else if (r_j != w_j_lim) begin
            w_k_nxt = '0;
            w_j_nxt = r_j + 1'b1;
        end else begin
            w_k_nxt = '0;
            w_j_nxt = '0;
            w_p_nxt = r_inv ? (r_p + 1'b1) : (r_p - 1'b1);
        end
    end

    assign w_last_nxt = (w_p_nxt == w_p_last) &&
                        (w_k_nxt == ADDR_W'(k_last(ADDR_W, int'(w_p_nxt)))) &&
                        (w_j_nxt == ADDR_W'(j_last(int'(w_p_nxt))));

    ntt_addr_map #(
        .ADDR_W (ADDR_W),
        .P_W    (P_W)
    ) u_map (
        .i_k      (w_k_nxt),
        .i_j      (w_j_nxt),
        .i_p      (w_p_nxt),
        .o_addr0  (w_a0),
        .o_addr1  (w_a1),
        .o_addr2  (w_a2),
        .o_addr3  (w_a3),
        .o_tw_exp (w_tw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_inv   <= 1'b0;
            r_gap   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state <= ST_RUN;
                        r_inv   <= inv;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_xfer) begin
                        if (w_final) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_stage_end && (STAGE_GAP > 0)) begin
                            r_state <= ST_GAP;
                            r_valid <= 1'b0;
                            r_gap   <= GAP_INIT;
                        end
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_gap == 4'd0) begin
                        r_state <= ST_RUN;
                        r_valid <= 1'b1;
                    end else begin
                        r_gap <= r_gap - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Counters and output tuple load together, so outputs always reflect (r_k, r_j, r_p).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k     <= '0;
            r_j     <= '0;
            r_p     <= '0;
            r_last  <= 1'b0;
            r_addr0 <= '0;
            r_addr1 <= '0;
            r_addr2 <= '0;
            r_addr3 <= '0;
            r_tw    <= '0;
        end else if (w_load) begin
            r_k     <= w_k_nxt;
            r_j     <= w_j_nxt;
            r_p     <= w_p_nxt;
            r_last  <= w_last_nxt;
            r_addr0 <= w_a0;
            r_addr1 <= w_a1;
            r_addr2 <= w_a2;
            r_addr3 <= w_a3;
            r_tw    <= w_tw;
        end else if (w_clr_last) begin
            r_last <= 1'b0;
        end
    end

    assign addr_if.addr_valid = r_valid;
    assign addr_if.addr0      = r_addr0;
    assign addr_if.addr1      = r_addr1;
    assign addr_if.addr2      = r_addr2;
    assign addr_if.addr3      = r_addr3;
    assign addr_if.tw_exp     = r_tw;
    assign addr_if.stage      = r_p;
    assign addr_if.last       = r_last;
    assign busy               = r_busy;
    assign done               = r_done;
endmodule
